// File: rtl/cuenta_puntos_bcd_multi.sv
// Multi-player BCD score counter: serial one-point-per-clock adds under a busy
// handshake, sticky per-player saturation at all-nines, and a high-score register.
module cuenta_puntos_bcd_multi #(
  parameter int NUM_DIGITS  = 4,
  parameter int NUM_PLAYERS = 2,
  parameter int STEP_W      = 4,
  localparam int PSEL_W     = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                                iClk,
  input  logic                                iReset_n,
  input  logic                                iClear,
  input  logic                                iEnableContar,
  input  logic [PSEL_W-1:0]                   iPlayer,
  input  logic [STEP_W-1:0]                   iPuntos,
  output logic [4*NUM_DIGITS*NUM_PLAYERS-1:0] oNumero,
  output logic [4*NUM_DIGITS-1:0]             oRecord,
  output logic                                oBusy,
  output logic [NUM_PLAYERS-1:0]              oSaturado,
  output logic                                oNuevoRecord
);

  localparam int SW = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {IDLE = 2'd0, ADD = 2'd1, CHECK = 2'd2} state_t;

  state_t                           state_r, next_state_s;
  logic [NUM_PLAYERS-1:0][SW-1:0]   scores_r;
  logic [SW-1:0]                    record_r;
  logic [PSEL_W-1:0]                player_r;
  logic [STEP_W-1:0]                remaining_r;
  logic [NUM_PLAYERS-1:0]           sat_r;
  logic                             busy_r;
  logic                             new_rec_r;
  logic [SW-1:0]                    cur_score_s;
  logic                             player_ok_s;
  logic                             accept_s;
  logic                             inc_s;
  logic                             sat_s;
  logic                             upd_s;

  // Ripple BCD increment: a 9 wraps to 0 and carries into the next digit.
  function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
    logic          carry;
    logic [3:0]    d;
    logic [SW-1:0] r;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = v[4*i +: 4];
      if (carry && (d == 4'd9)) begin
        r[4*i +: 4] = 4'd0;
      end else if (carry) begin
        r[4*i +: 4] = d + 4'd1;
        carry       = 1'b0;
      end else begin
        r[4*i +: 4] = d;
      end
    end
    return r;
  endfunction

  function automatic logic all_nines(input logic [SW-1:0] v);
    return (v == {NUM_DIGITS{4'h9}});
  endfunction

  assign player_ok_s = ({{(32-PSEL_W){1'b0}}, iPlayer} < 32'(NUM_PLAYERS));

  // Select the score of the latched player.
  always_comb begin
    cur_score_s = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      cur_score_s = (player_r == PSEL_W'(p)) ? scores_r[p] : cur_score_s;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    inc_s        = 1'b0;
    sat_s        = 1'b0;
    upd_s        = 1'b0;
    if (iClear) begin
      next_state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (iEnableContar && (iPuntos != '0) && player_ok_s) begin
            accept_s     = 1'b1;
            next_state_s = ADD;
          end else begin
            next_state_s = IDLE;
          end
        end
        ADD: begin
          if (all_nines(cur_score_s)) begin
            sat_s        = 1'b1;
            next_state_s = CHECK;
          end else if (remaining_r == STEP_W'(1)) begin
            inc_s        = 1'b1;
            next_state_s = CHECK;
          end else begin
            inc_s        = 1'b1;
            next_state_s = ADD;
          end
        end
        CHECK: begin
          // Valid BCD digits order the same as their packed binary value.
          upd_s        = (cur_score_s > record_r);
          next_state_s = IDLE;
        end
        default: next_state_s = IDLE;
      endcase
    end
  end

  // State register and registered busy flag.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s != IDLE);
    end
  end

  // Scores, request bookkeeping, saturation flags and high score.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      scores_r    <= '0;
      record_r    <= '0;
      player_r    <= '0;
      remaining_r <= '0;
      sat_r       <= '0;
      new_rec_r   <= 1'b0;
    end else if (iClear) begin
      scores_r    <= '0;
      player_r    <= '0;
      remaining_r <= '0;
      sat_r       <= '0;
      new_rec_r   <= 1'b0;
    end else begin
      new_rec_r <= upd_s;
      if (accept_s) begin
        player_r    <= iPlayer;
        remaining_r <= iPuntos;
      end
      if (inc_s) begin
        remaining_r <= remaining_r - STEP_W'(1);
      end
      if (sat_s) begin
        remaining_r <= '0;
      end
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (inc_s && (player_r == PSEL_W'(p))) scores_r[p] <= bcd_inc(cur_score_s);
        if (sat_s && (player_r == PSEL_W'(p))) sat_r[p]    <= 1'b1;
      end
      if (upd_s) begin
        record_r <= cur_score_s;
      end
    end
  end

  assign oNumero      = scores_r;
  assign oRecord      = record_r;
  assign oBusy        = busy_r;
  assign oSaturado    = sat_r;
  assign oNuevoRecord = new_rec_r;

endmodule

// File: tb/tb_cuenta_puntos_bcd_multi.sv
// Directed bench for cuenta_puntos_bcd_multi with 2 digits and 3 players, so that
// saturation is reachable and player index 3 is out of range.
module tb_cuenta_puntos_bcd_multi;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr   = 1'b0;
  logic        en    = 1'b0;
  logic [1:0]  pl    = 2'd0;
  logic [3:0]  pts   = 4'd0;
  logic [23:0] numero;
  logic [7:0]  record;
  logic        busy;
  logic [2:0]  sat;
  logic        nuevo;

  int n_cmp   = 0;
  int n_err   = 0;
  int bad_bcd = 0;
  int bc, pc;

  always #5 clk = ~clk;

  cuenta_puntos_bcd_multi #(.NUM_DIGITS(2), .NUM_PLAYERS(3), .STEP_W(4)) dut (
    .iClk(clk), .iReset_n(rst_n), .iClear(clr), .iEnableContar(en),
    .iPlayer(pl), .iPuntos(pts), .oNumero(numero), .oRecord(record),
    .oBusy(busy), .oSaturado(sat), .oNuevoRecord(nuevo)
  );

  // Any nibble above 9 on any score is illegal at any time.
  always @(negedge clk) begin
    for (int i = 0; i < 6; i++) begin
      if (numero[4*i +: 4] > 4'd9) bad_bcd++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_req(input logic [1:0] p, input logic [3:0] n,
                         output int busy_cyc, output int pulses);
    @(negedge clk); en = 1'b1; pl = p; pts = n;
    @(negedge clk); en = 1'b0; pts = 4'd0;
    busy_cyc = 0;
    pulses   = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      busy_cyc++;
      if (nuevo) pulses++;
      @(negedge clk);
    end
    check_eq("req_done", busy, 1'b0);
    for (int i = 0; i < 2; i++) begin
      if (nuevo) pulses++;
      @(negedge clk);
    end
  endtask

  initial begin
    #7;
    check_eq("rst_num", numero, 24'h0);
    check_eq("rst_rec", record, 8'h0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_sat", sat, 3'b000);
    check_eq("rst_new", nuevo, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    // Basic add of 5 points
    run_req(2'd0, 4'd5, bc, pc);
    check_eq("t1_busy", bc, 6);
    check_eq("t1_pulse", pc, 1);
    check_eq("t1_num", numero, 24'h000005);
    check_eq("t1_rec", record, 8'h05);

    // BCD carry 08 + 3 = 11
    run_req(2'd0, 4'd3, bc, pc);
    check_eq("t2_p0a", numero[7:0], 8'h08);
    run_req(2'd0, 4'd3, bc, pc);
    check_eq("t2_num", numero, 24'h000011);
    check_eq("t2_rec", record, 8'h11);
    check_eq("t2_pulse", pc, 1);

    // Ignored requests: zero points, out-of-range player, request while busy
    @(negedge clk); en = 1'b1; pl = 2'd0; pts = 4'd0;
    @(negedge clk); en = 1'b0;
    check_eq("t5_zero_busy", busy, 1'b0);
    @(negedge clk); en = 1'b1; pl = 2'd3; pts = 4'd5;
    @(negedge clk); en = 1'b0; pts = 4'd0;
    check_eq("t5_pl3_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    check_eq("t5_pl3_num", numero, 24'h000011);
    @(negedge clk); en = 1'b1; pl = 2'd1; pts = 4'd2;
    @(negedge clk); pl = 2'd2; pts = 4'd3;
    check_eq("t5_busy_on", busy, 1'b1);
    @(negedge clk); en = 1'b0; pts = 4'd0;
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check_eq("t5_num", numero, 24'h000211);
    check_eq("t5_rec", record, 8'h11);

    // New-game clear keeps the high score
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    check_eq("clr_num", numero, 24'h0);
    check_eq("clr_rec", record, 8'h11);

    // Saturation on player 1
    repeat (6) run_req(2'd1, 4'd15, bc, pc);
    run_req(2'd1, 4'd9, bc, pc);
    check_eq("t3_p1_99", numero, 24'h009900);
    check_eq("t3_rec99", record, 8'h99);
    check_eq("t3_sat0", sat, 3'b000);
    run_req(2'd1, 4'd4, bc, pc);
    check_eq("t3_busy", bc, 2);
    check_eq("t3_pulse", pc, 0);
    check_eq("t3_num", numero, 24'h009900);
    check_eq("t3_sat", sat, 3'b010);
    run_req(2'd1, 4'd1, bc, pc);
    check_eq("t3_again_busy", bc, 2);
    check_eq("t3_again_sat", sat, 3'b010);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    check_eq("t3_clr_num", numero, 24'h0);
    check_eq("t3_clr_sat", sat, 3'b000);
    check_eq("t3_clr_rec", record, 8'h99);

    // Clear on the 4th ADD cycle of a 10-point request
    @(negedge clk); en = 1'b1; pl = 2'd1; pts = 4'd10;
    @(negedge clk); en = 1'b0; pts = 4'd0;
    repeat (3) @(negedge clk);
    check_eq("t4_mid", numero[15:8], 8'h03);
    clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    check_eq("t4_num", numero, 24'h0);
    check_eq("t4_busy", busy, 1'b0);
    check_eq("t4_new", nuevo, 1'b0);
    check_eq("t4_rec", record, 8'h99);
    @(negedge clk);
    check_eq("t4_new2", nuevo, 1'b0);

    // Record rules after a fresh reset
    @(negedge clk); rst_n = 1'b0;
    #1 check_eq("t6_rst_rec", record, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    run_req(2'd0, 4'd7, bc, pc);
    check_eq("t6_p0_pulse", pc, 1);
    check_eq("t6_rec7", record, 8'h07);
    run_req(2'd1, 4'd7, bc, pc);
    check_eq("t6_eq_pulse", pc, 0);
    check_eq("t6_eq_rec", record, 8'h07);
    run_req(2'd1, 4'd1, bc, pc);
    check_eq("t6_gt_pulse", pc, 1);
    check_eq("t6_rec8", record, 8'h08);
    check_eq("t6_num", numero, 24'h000807);

    // Async reset in the middle of a request
    @(negedge clk); en = 1'b1; pl = 2'd2; pts = 4'd9;
    @(negedge clk); en = 1'b0; pts = 4'd0;
    repeat (2) @(negedge clk);
    check_eq("t6_mid_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_ar_num", numero, 24'h0);
    check_eq("t6_ar_rec", record, 8'h0);
    check_eq("t6_ar_busy", busy, 1'b0);
    check_eq("t6_ar_sat", sat, 3'b000);
    check_eq("t6_ar_new", nuevo, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    check_eq("bcd_digits", bad_bcd, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
